// File: rtl/accum_buf_ctrl.sv
// Tile sequencer for one accum_buf ping-pong pair: preload/store the idle bank on port B while the PE
// array accumulates into the active bank, then swap banks once both sides are finished.
module accum_buf_ctrl #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int BATCH  = 32,
  parameter int RES_W  = 16,
  parameter int RD_LAT = 2,
  parameter int DRAIN  = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tile_valid,
  output logic                     tile_ready,
  input  logic [ADDR_W-1:0]        tile_len,
  input  logic                     tile_ld,
  input  logic                     tile_flush,
  output logic                     acc_start,
  output logic                     acc_new,
  output logic [ADDR_W-1:0]        acc_len,
  input  logic                     acc_done,
  output logic                     switch,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [BATCH*RES_W-1:0]   ld_data,
  output logic [ADDR_W-1:0]        ld_wr_addr,
  output logic [BATCH*RES_W-1:0]   ld_wr_data,
  output logic                     ld_wr_en,
  output logic [ADDR_W-1:0]        sv_rd_addr,
  input  logic [BATCH*RES_W-1:0]   sv_rd_data,
  output logic                     sv_valid,
  input  logic                     sv_ready,
  output logic [BATCH*RES_W-1:0]   sv_data,
  output logic                     sv_last,
  output logic                     busy
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_STORE  = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_ARMED  = 3'd3;
  localparam logic [2:0] S_SWITCH = 3'd4;

  logic [2:0]        state;
  logic [ADDR_W-1:0] len, res_len, rd_ptr, out_cnt, ld_ptr;
  logic              ld_f, flush_f;
  logic              acc_busy, acc_has, res_pend;
  logic              drain_act;
  logic [7:0]        drain_cnt;
  logic              rd_done;

  logic [RD_LAT-1:0]      vld_pipe;
  logic [BATCH*RES_W-1:0] fifo_mem [4];
  logic [1:0]             fifo_wp, fifo_rp;
  logic [2:0]             fifo_cnt;
  logic [3:0]             inflight;
  logic                   rd_issue, fifo_push, sv_pop;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + 4'(vld_pipe[i]);
  end

  // Reads are only issued when the FIFO is guaranteed a slot for every word still in the RAM pipe,
  // so back-pressure on the result stream can never drop a word.
  assign rd_issue  = (state == S_STORE) && !rd_done && (({1'b0, fifo_cnt} + inflight) < 4'd4);
  assign fifo_push = vld_pipe[RD_LAT-1];
  assign sv_valid  = (fifo_cnt != 3'd0);
  assign sv_pop    = sv_valid && sv_ready;
  assign sv_data   = sv_valid ? fifo_mem[fifo_rp] : '0;
  assign sv_last   = sv_valid && (out_cnt == res_len);
  assign sv_rd_addr = rd_ptr;

  assign tile_ready = (state == S_IDLE);
  assign ld_ready   = (state == S_LOAD);
  assign ld_wr_en   = ld_ready && ld_valid;
  assign ld_wr_addr = ld_ptr;
  assign ld_wr_data = ld_wr_en ? ld_data : '0;
  assign switch     = (state == S_SWITCH);
  assign busy       = (state != S_IDLE) || acc_busy || res_pend;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      fifo_wp  <= '0;
      fifo_rp  <= '0;
      fifo_cnt <= '0;
    end else begin
      vld_pipe[0] <= rd_issue;
      for (int i = 1; i < RD_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
      if (fifo_push) fifo_wp <= fifo_wp + 2'd1;
      if (sv_pop)    fifo_rp <= fifo_rp + 2'd1;
      case ({fifo_push, sv_pop})
        2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_push) fifo_mem[fifo_wp] <= sv_rd_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      len       <= '0;
      ld_f      <= 1'b0;
      flush_f   <= 1'b0;
      res_len   <= '0;
      rd_ptr    <= '0;
      rd_done   <= 1'b0;
      out_cnt   <= '0;
      ld_ptr    <= '0;
      acc_busy  <= 1'b0;
      acc_has   <= 1'b0;
      res_pend  <= 1'b0;
      acc_start <= 1'b0;
      acc_new   <= 1'b0;
      acc_len   <= '0;
      drain_act <= 1'b0;
      drain_cnt <= '0;
    end else begin
      acc_start <= 1'b0;
      case (state)
        S_IDLE: if (tile_valid) begin
          len     <= tile_len;
          ld_f    <= tile_ld;
          flush_f <= tile_flush;
          rd_ptr  <= '0;
          rd_done <= 1'b0;
          out_cnt <= '0;
          ld_ptr  <= '0;
          if (res_pend)                  state <= S_STORE;
          else if (tile_ld && !tile_flush) state <= S_LOAD;
          else                           state <= S_ARMED;
        end
        S_STORE: begin
          if (rd_issue) begin
            if (rd_ptr == res_len) rd_done <= 1'b1;
            else                   rd_ptr  <= rd_ptr + ADDR_W'(1);
          end
          if (sv_pop) out_cnt <= out_cnt + ADDR_W'(1);
          if (sv_pop && sv_last) begin
            res_pend <= 1'b0;
            state    <= (ld_f && !flush_f) ? S_LOAD : S_ARMED;
          end
        end
        S_LOAD: if (ld_valid) begin
          if (ld_ptr == len) state <= S_ARMED;
          else               ld_ptr <= ld_ptr + ADDR_W'(1);
        end
        S_ARMED: if (!acc_busy) state <= S_SWITCH;
        S_SWITCH: begin
          res_pend <= acc_has;
          res_len  <= acc_len;
          acc_has  <= 1'b0;
          if (!flush_f) begin
            acc_start <= 1'b1;
            acc_new   <= !ld_f;
            acc_len   <= len;
            acc_busy  <= 1'b1;
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      // SWITCH requires !acc_busy, so it never collides with the drain completing.
      if (drain_act) begin
        if (drain_cnt == 8'd0) begin
          drain_act <= 1'b0;
          acc_busy  <= 1'b0;
          acc_has   <= 1'b1;
        end else begin
          drain_cnt <= drain_cnt - 8'd1;
        end
      end else if (acc_done && acc_busy) begin
        drain_act <= 1'b1;
        drain_cnt <= 8'(DRAIN - 1);
      end
    end
  end

endmodule

// File: tb/tb_accum_buf_ctrl.sv
// Directed bench for accum_buf_ctrl with a 2-cycle RAM read model, a PE done-pulse model and a
// preload source; handshakes are logged at the falling edge and checked against hand-derived values.
module tb_accum_buf_ctrl;
  localparam int DRAIN = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        tile_valid, tile_ready, tile_ld, tile_flush;
  logic [7:0]  tile_len, acc_len, ld_wr_addr, sv_rd_addr;
  logic        acc_start, acc_new, acc_done, switch;
  logic        ld_valid, ld_ready, ld_wr_en;
  logic [31:0] ld_data, ld_wr_data, sv_rd_data, sv_data;
  logic        sv_valid, sv_ready, sv_last, busy;

  accum_buf_ctrl #(.DEPTH(256), .BATCH(4), .RES_W(8), .RD_LAT(2), .DRAIN(DRAIN)) dut (
    .clk(clk), .rst(rst),
    .tile_valid(tile_valid), .tile_ready(tile_ready), .tile_len(tile_len),
    .tile_ld(tile_ld), .tile_flush(tile_flush),
    .acc_start(acc_start), .acc_new(acc_new), .acc_len(acc_len), .acc_done(acc_done),
    .switch(switch),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
    .ld_wr_addr(ld_wr_addr), .ld_wr_data(ld_wr_data), .ld_wr_en(ld_wr_en),
    .sv_rd_addr(sv_rd_addr), .sv_rd_data(sv_rd_data),
    .sv_valid(sv_valid), .sv_ready(sv_ready), .sv_data(sv_data), .sv_last(sv_last),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // accum_buf port-B read model: data for an address appears two cycles after it is presented
  logic [7:0] p1, p2;
  always @(posedge clk) begin
    p1 <= sv_rd_addr;
    p2 <= p1;
  end
  assign sv_rd_data = 32'hC0DE_0000 | {24'd0, p2};

  int n_chk = 0, n_fail = 0;
  int cyc_n = 0, n_sw = 0, n_start = 0;
  int sw_cyc, st_cyc, done_cyc, ld_cyc, sv_cyc;
  logic       st_new;
  logic [7:0] st_len;
  logic [7:0]  lda_q[$];
  logic [31:0] ldd_q[$];
  logic [31:0] svd_q[$];
  logic        svl_q[$];
  int  pe_delay = 10;
  int  ld_idx = 0;
  logic tog = 1'b0;
  int  ld0, sw0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial forever begin
    @(posedge clk);
    cyc_n++;
  end

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (switch) begin n_sw++; sw_cyc = cyc_n; end
      if (acc_start) begin n_start++; st_new = acc_new; st_len = acc_len; st_cyc = cyc_n; end
      if (acc_done) done_cyc = cyc_n;
      if (ld_wr_en) begin lda_q.push_back(ld_wr_addr); ldd_q.push_back(ld_wr_data); ld_cyc = cyc_n; end
      if (sv_valid && sv_ready) begin svd_q.push_back(sv_data); svl_q.push_back(sv_last); sv_cyc = cyc_n; end
    end
  end

  // PE: pulse acc_done pe_delay cycles after each acc_start
  initial begin
    acc_done = 1'b0;
    forever begin
      @(negedge clk);
      if (acc_start && !rst) begin
        repeat (pe_delay) @(posedge clk);
        #1 acc_done = 1'b1;
        @(posedge clk);
        #1 acc_done = 1'b0;
      end
    end
  end

  // preload source: always valid, advances one word per accepted handshake
  initial begin
    logic hs;
    ld_valid = 1'b1;
    ld_data  = 32'hA000_0000;
    forever begin
      @(negedge clk);
      hs = ld_valid && ld_ready;
      @(posedge clk);
      #1;
      if (hs) ld_idx++;
      ld_data = 32'hA000_0000 | 32'(ld_idx);
    end
  end

  initial begin
    sv_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 sv_ready = tog ? ~sv_ready : 1'b1;
    end
  end

  task automatic send_tile(input logic [7:0] l, input logic ld, input logic fl);
    for (int i = 0; i < 4000 && !tile_ready; i++) step();
    check("tile_ready wait", 32'(tile_ready), 32'd1);
    tile_valid = 1'b1; tile_len = l; tile_ld = ld; tile_flush = fl;
    step();
    tile_valid = 1'b0; tile_len = '0; tile_ld = 1'b0; tile_flush = 1'b0;
  endtask

  task automatic wait_sw(input int n, input string tag);
    for (int i = 0; i < 4000 && n_sw < n; i++) step();
    check(tag, 32'(n_sw), 32'(n));
  endtask

  task automatic wait_start(input int n, input string tag);
    for (int i = 0; i < 4000 && n_start < n; i++) step();
    check(tag, 32'(n_start), 32'(n));
  endtask

  task automatic chk_store(input string tag, input int n);
    check({tag, " count"}, 32'(svd_q.size()), 32'(n));
    for (int i = 0; i < n && i < svd_q.size(); i++) begin
      check({tag, " data"}, svd_q[i], 32'hC0DE_0000 | 32'(i));
      check({tag, " last"}, 32'(svl_q[i]), 32'(i == n - 1));
    end
  endtask

  task automatic chk_load(input string tag, input int n);
    check({tag, " count"}, 32'(lda_q.size()), 32'(n));
    for (int i = 0; i < n && i < lda_q.size(); i++) begin
      check({tag, " addr"}, 32'(lda_q[i]), 32'(i));
      check({tag, " data"}, ldd_q[i], 32'hA000_0000 | 32'(ld0 + i));
    end
  endtask

  task automatic chk_reset(input string tag);
    check({tag, " tile_ready"}, 32'(tile_ready), 32'd1);
    check({tag, " switch"},     32'(switch),     32'd0);
    check({tag, " acc_start"},  32'(acc_start),  32'd0);
    check({tag, " acc_new"},    32'(acc_new),    32'd0);
    check({tag, " acc_len"},    32'(acc_len),    32'd0);
    check({tag, " ld_ready"},   32'(ld_ready),   32'd0);
    check({tag, " ld_wr_en"},   32'(ld_wr_en),   32'd0);
    check({tag, " ld_wr_data"}, ld_wr_data,      32'd0);
    check({tag, " sv_rd_addr"}, 32'(sv_rd_addr), 32'd0);
    check({tag, " sv_valid"},   32'(sv_valid),   32'd0);
    check({tag, " sv_data"},    sv_data,         32'd0);
    check({tag, " sv_last"},    32'(sv_last),    32'd0);
    check({tag, " busy"},       32'(busy),       32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; tile_valid = 1'b0; tile_len = '0; tile_ld = 1'b0; tile_flush = 1'b0;
    step(); step();
    chk_reset("reset");
    rst = 1'b0;
    step();

    // T1: fresh tile, flush to switch, second flush streams the 4 results
    pe_delay = 10;
    send_tile(8'd3, 1'b0, 1'b0);
    wait_start(1, "t1 start");
    check("t1 acc_new", 32'(st_new), 32'd1);
    check("t1 acc_len", 32'(st_len), 32'd3);
    check("t1 sw count", 32'(n_sw), 32'd1);
    send_tile(8'd0, 1'b0, 1'b1);
    wait_sw(2, "t1 flush sw");
    check("t1 no restart", 32'(n_start), 32'd1);
    check("t1 pending busy", 32'(busy), 32'd1);
    check("t1 no early store", 32'(svd_q.size()), 32'd0);
    send_tile(8'd0, 1'b0, 1'b1);
    wait_sw(3, "t1 store sw");
    chk_store("t1", 4);
    check("t1 idle busy", 32'(busy), 32'd0);

    // T2: preload 8 words, accumulation starts only afterwards
    pe_delay = 5;
    lda_q.delete(); ldd_q.delete(); ld0 = ld_idx;
    send_tile(8'd7, 1'b1, 1'b0);
    wait_start(2, "t2 start");
    chk_load("t2", 8);
    check("t2 acc_new", 32'(st_new), 32'd0);
    check("t2 acc_len", 32'(st_len), 32'd7);
    check("t2 start after load", 32'(st_cyc > ld_cyc), 32'd1);
    send_tile(8'd0, 1'b0, 1'b1);
    wait_sw(5, "t2 flush sw");

    // T3: stores under sv_ready toggling every cycle
    tog = 1'b1;
    svd_q.delete(); svl_q.delete();
    send_tile(8'd15, 1'b0, 1'b0);
    wait_start(3, "t3 start");
    chk_store("t3a", 8);
    send_tile(8'd0, 1'b0, 1'b1);
    wait_sw(7, "t3 flush sw");
    svd_q.delete(); svl_q.delete();
    send_tile(8'd0, 1'b0, 1'b1);
    wait_sw(8, "t3 store sw");
    chk_store("t3b", 16);
    tog = 1'b0;

    // T4: next tile prepared while the PE is still busy; switch waits for the drain
    pe_delay = 5;
    send_tile(8'd3, 1'b0, 1'b0);
    wait_start(4, "t4 start a");
    pe_delay = 60;
    send_tile(8'd4, 1'b0, 1'b0);
    wait_start(5, "t4 start b");
    pe_delay = 5;
    svd_q.delete(); svl_q.delete(); lda_q.delete(); ldd_q.delete(); ld0 = ld_idx;
    send_tile(8'd5, 1'b1, 1'b0);
    repeat (40) step();
    check("t4 held sw", 32'(n_sw), 32'd10);
    chk_store("t4", 4);
    chk_load("t4", 6);
    check("t4 busy", 32'(busy), 32'd1);
    wait_sw(11, "t4 sw");
    check("t4 drain gap", 32'((sw_cyc - done_cyc) >= DRAIN), 32'd1);
    check("t4 sw after store", 32'(sw_cyc > sv_cyc), 32'd1);
    check("t4 sw after load", 32'(sw_cyc > ld_cyc), 32'd1);
    wait_start(6, "t4 start c");
    check("t4 acc_new", 32'(st_new), 32'd0);
    check("t4 acc_len", 32'(st_len), 32'd5);
    send_tile(8'd0, 1'b0, 1'b1);
    wait_sw(12, "t4 flush sw");

    // T5: full-bank preload and store
    svd_q.delete(); svl_q.delete(); lda_q.delete(); ldd_q.delete(); ld0 = ld_idx;
    send_tile(8'd255, 1'b1, 1'b0);
    wait_start(7, "t5 start");
    chk_store("t5 prev", 6);
    chk_load("t5", 256);
    check("t5 acc_len", 32'(st_len), 32'd255);
    send_tile(8'd0, 1'b0, 1'b1);
    wait_sw(14, "t5 flush sw");
    svd_q.delete(); svl_q.delete();
    send_tile(8'd0, 1'b0, 1'b1);
    wait_sw(15, "t5 store sw");
    chk_store("t5", 256);
    check("t5 idle busy", 32'(busy), 32'd0);

    // T6: reset in the middle of a store loses the partial results
    pe_delay = 3;
    send_tile(8'd9, 1'b0, 1'b0);
    wait_start(8, "t6 start");
    send_tile(8'd0, 1'b0, 1'b1);
    wait_sw(17, "t6 flush sw");
    svd_q.delete(); svl_q.delete();
    send_tile(8'd0, 1'b0, 1'b1);
    for (int i = 0; i < 4000 && svd_q.size() < 3; i++) step();
    check("t6 partial store", 32'(svd_q.size() >= 3), 32'd1);
    rst = 1'b1;
    step();
    chk_reset("t6 reset");
    rst = 1'b0;
    step();
    svd_q.delete(); svl_q.delete();
    sw0 = n_sw;
    send_tile(8'd0, 1'b0, 1'b1);
    wait_sw(sw0 + 1, "t6 sw");
    repeat (5) step();
    check("t6 no store", 32'(svd_q.size()), 32'd0);
    check("t6 busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
